// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode constants and retire observation helpers
//
// Purpose: opcode and halt-word constants shared by the control unit and the
// retirement monitor, plus the opcode -> observation-source decode.
// Ports: none (package).

package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x1,x0,12 ; jalr x0,0(x1)
    localparam logic [31:0] HALT_INST0_DEF = 32'h00c00093;
    localparam logic [31:0] HALT_INST1_DEF = 32'h00008067;

    typedef enum logic [1:0] {
        SEL_WB   = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_BR   = 2'd2,
        SEL_HOLD = 2'd3
    } obs_sel_e;

    // Which retire field becomes the observation value for a given opcode.
    function automatic obs_sel_e obs_sel(input logic [6:0] opc);
        obs_sel_e sel;
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD:            sel = SEL_WB;
            OPC_STORE:                              sel = SEL_MEM;
            OPC_BRANCH:                             sel = SEL_BR;
            default:                                sel = SEL_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/riscv_retire_wdog.sv
// rtl/riscv_retire_wdog.sv - idle-cycle watchdog with sticky timeout flag
//
// Purpose: counts cycles without a retire pulse and raises a sticky TIMEOUT
// when the count reaches WDOG_CYCLES. WDOG_CYCLES=0 disables it.
// Ports:
//   CLK          in  clock
//   RST          in  synchronous active-high reset
//   RETIRE_VALID in  retire pulse, clears the idle count
//   HALT         in  core halted, freezes the count
//   TIMEOUT      out sticky watchdog-expired flag (registered)

module riscv_retire_wdog #(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic CLK,
    input  logic RST,
    input  logic RETIRE_VALID,
    input  logic HALT,
    output logic TIMEOUT
);

    // Keep at least one bit so the disabled configuration still elaborates.
    localparam int CW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;

    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          timeout_q,  timeout_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        timeout_d  = timeout_q;
        if (RETIRE_VALID) begin
            // A retire in the expiry cycle wins: no timeout this edge.
            idle_cnt_d = '0;
        end else if (!(HALT || timeout_q)) begin
            idle_cnt_d = idle_cnt_q + CW'(1);
            if ((WDOG_CYCLES != 0) && (idle_cnt_d == CW'(WDOG_CYCLES))) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;

endmodule

// File: rtl/riscv_retire_monitor.sv
// rtl/riscv_retire_monitor.sv - retirement observation producer (NUM_INST/OUTPUT_PORT/HALT/TIMEOUT)
//
// Purpose: consumes one retire pulse per completed instruction and publishes
// registered observation values for the external checker.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   RETIRE_VALID      one-cycle pulse per completed instruction
//   RETIRE_INST       instruction word of the retiring instruction
//   RETIRE_WB_DATA    register-file write data of that instruction
//   RETIRE_MEM_ADDR   effective data-memory address (stores)
//   RETIRE_BR_TAKEN   branch outcome (branches)
//   NUM_INST          saturating count of accepted retires
//   OUTPUT_PORT       observation value of the last retired instruction
//   HALT              sticky, halt pair retired
//   TIMEOUT           sticky, watchdog expired

module riscv_retire_monitor
    import riscv_pkg::*;
#(
    parameter logic [31:0] HALT_INST0  = HALT_INST0_DEF,
    parameter logic [31:0] HALT_INST1  = HALT_INST1_DEF,
    parameter int          WDOG_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RETIRE_VALID,
    input  logic [31:0] RETIRE_INST,
    input  logic [31:0] RETIRE_WB_DATA,
    input  logic [31:0] RETIRE_MEM_ADDR,
    input  logic        RETIRE_BR_TAKEN,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT,
    output logic        TIMEOUT
);

    logic [31:0] num_inst_q,    num_inst_d;
    logic [31:0] output_port_q, output_port_d;
    logic        halt_q,        halt_d;
    logic [31:0] prev_inst_q,   prev_inst_d;
    logic        prev_valid_q,  prev_valid_d;

    logic accept;

    // Once halted the core is considered stopped; stray pulses are dropped.
    assign accept = RETIRE_VALID && !halt_q;

    always_comb begin
        num_inst_d    = num_inst_q;
        output_port_d = output_port_q;
        halt_d        = halt_q;
        prev_inst_d   = prev_inst_q;
        prev_valid_d  = prev_valid_q;

        if (accept) begin
            if (num_inst_q != 32'hFFFF_FFFF) begin
                num_inst_d = num_inst_q + 32'd1;
            end

            case (obs_sel(RETIRE_INST[6:0]))
                SEL_WB:   output_port_d = RETIRE_WB_DATA;
                SEL_MEM:  output_port_d = RETIRE_MEM_ADDR;
                SEL_BR:   output_port_d = {31'b0, RETIRE_BR_TAKEN};
                default:  output_port_d = output_port_q;
            endcase

            // The pair only matches on consecutive retires; idle cycles
            // leave prev_inst untouched and so do not break it.
            if ((RETIRE_INST == HALT_INST1) && prev_valid_q &&
                (prev_inst_q == HALT_INST0)) begin
                halt_d = 1'b1;
            end

            prev_inst_d  = RETIRE_INST;
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            num_inst_q    <= '0;
            output_port_q <= '0;
            halt_q        <= 1'b0;
            prev_inst_q   <= '0;
            prev_valid_q  <= 1'b0;
        end else begin
            num_inst_q    <= num_inst_d;
            output_port_q <= output_port_d;
            halt_q        <= halt_d;
            prev_inst_q   <= prev_inst_d;
            prev_valid_q  <= prev_valid_d;
        end
    end

    riscv_retire_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .CLK          (CLK),
        .RST          (RST),
        .RETIRE_VALID (RETIRE_VALID),
        .HALT         (halt_q),
        .TIMEOUT      (TIMEOUT)
    );

    assign NUM_INST    = num_inst_q;
    assign OUTPUT_PORT = output_port_q;
    assign HALT        = halt_q;

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// tb/tb_riscv_retire_monitor.sv - self-checking bench for riscv_retire_monitor

module tb_riscv_retire_monitor;

    localparam int WD = 8;
    localparam logic [31:0] H0 = 32'h00c00093;
    localparam logic [31:0] H1 = 32'h00008067;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RETIRE_VALID = 1'b0;
    logic [31:0] RETIRE_INST = '0;
    logic [31:0] RETIRE_WB_DATA = '0;
    logic [31:0] RETIRE_MEM_ADDR = '0;
    logic        RETIRE_BR_TAKEN = 1'b0;
    logic [31:0] NUM_INST, OUTPUT_PORT;
    logic        HALT, TIMEOUT;
    logic [31:0] NUM_INST_z, OUTPUT_PORT_z;
    logic        HALT_z, TIMEOUT_z;

    always #5 CLK = ~CLK;

    riscv_retire_monitor #(.WDOG_CYCLES(WD)) dut (
        .CLK(CLK), .RST(RST), .RETIRE_VALID(RETIRE_VALID), .RETIRE_INST(RETIRE_INST),
        .RETIRE_WB_DATA(RETIRE_WB_DATA), .RETIRE_MEM_ADDR(RETIRE_MEM_ADDR),
        .RETIRE_BR_TAKEN(RETIRE_BR_TAKEN), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT),
        .HALT(HALT), .TIMEOUT(TIMEOUT)
    );

    riscv_retire_monitor #(.WDOG_CYCLES(0)) dut_nowd (
        .CLK(CLK), .RST(RST), .RETIRE_VALID(RETIRE_VALID), .RETIRE_INST(RETIRE_INST),
        .RETIRE_WB_DATA(RETIRE_WB_DATA), .RETIRE_MEM_ADDR(RETIRE_MEM_ADDR),
        .RETIRE_BR_TAKEN(RETIRE_BR_TAKEN), .NUM_INST(NUM_INST_z), .OUTPUT_PORT(OUTPUT_PORT_z),
        .HALT(HALT_z), .TIMEOUT(TIMEOUT_z)
    );

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // Reference state of the observation interface.
    logic [31:0] m_cnt, m_out, m_prev;
    logic        m_pv, m_halt, m_to;
    int          m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [31:0] inst,
                              input logic [31:0] wb, input logic [31:0] mem, input logic br);
        logic was_halt;
        logic was_to;
        was_halt = m_halt;
        was_to   = m_to;
        if (rst) begin
            m_cnt = 0; m_out = 0; m_prev = 0; m_pv = 0; m_halt = 0; m_to = 0; m_idle = 0;
        end else begin
            if (v && !was_halt) begin
                if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
                case (inst[6:0])
                    7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03: m_out = wb;
                    7'h23: m_out = mem;
                    7'h63: m_out = {31'b0, br};
                    default: ;
                endcase
                if (inst == H1 && m_pv && m_prev == H0) m_halt = 1;
                m_prev = inst;
                m_pv   = 1;
            end
            if (v) m_idle = 0;
            else if (!was_halt && !was_to) begin
                m_idle = m_idle + 1;
                if (m_idle == WD) m_to = 1;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [31:0] inst,
                         input logic [31:0] wb, input logic [31:0] mem, input logic br);
        RST = rst; RETIRE_VALID = v; RETIRE_INST = inst;
        RETIRE_WB_DATA = wb; RETIRE_MEM_ADDR = mem; RETIRE_BR_TAKEN = br;
        @(posedge CLK);
        model_step(rst, v, inst, wb, mem, br);
        #1;
        RST = 1'b0; RETIRE_VALID = 1'b0;
        chk("num_inst", NUM_INST, m_cnt);
        chk("output_port", OUTPUT_PORT, m_out);
        chk("halt", {31'b0, HALT}, {31'b0, m_halt});
        chk("timeout", {31'b0, TIMEOUT}, {31'b0, m_to});
        chk("timeout_disabled", {31'b0, TIMEOUT_z}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic retire(input logic [31:0] inst, input logic [31:0] wb,
                          input logic [31:0] mem, input logic br);
        cycle(0, 1, inst, wb, mem, br);
    endtask

    function automatic logic [31:0] rand_inst(input logic [31:0] last);
        logic [6:0] opcs [9];
        logic [31:0] w;
        int r;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h63};
        if (last == H0 && $urandom_range(0, 1) == 0) return H1;
        r = $urandom_range(0, 11);
        w = $urandom;
        if (r < 9) return {w[31:7], opcs[r]};
        if (r == 9) return H0;
        if (r == 10) return H1;
        return w;
    endfunction

    initial begin
        logic [31:0] inst, last;
        logic        v;

        m_cnt = 0; m_out = 0; m_prev = 0; m_pv = 0; m_halt = 0; m_to = 0; m_idle = 0;

        // Reset
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_num", NUM_INST, 32'd0);
        chk("reset_out", OUTPUT_PORT, 32'd0);

        // addi
        retire(32'h00500093, 32'd5, 0, 0);
        chk("addi_num", NUM_INST, 32'd1);
        chk("addi_out", OUTPUT_PORT, 32'd5);

        // sw then beq back-to-back
        retire(32'h0020a023, 32'hdeadbeef, 32'h104, 0);
        chk("sw_out", OUTPUT_PORT, 32'h104);
        retire(32'h00208463, 32'h12345678, 32'h999, 1);
        chk("beq_out", OUTPUT_PORT, 32'h1);
        chk("beq_num", NUM_INST, 32'd3);

        // Unknown opcode holds OUTPUT_PORT but counts
        retire(32'h0000000f, 32'h55, 32'h66, 0);
        chk("fence_out", OUTPUT_PORT, 32'h1);
        chk("fence_num", NUM_INST, 32'd4);

        // Halt pair
        retire(H0, 32'd12, 0, 0);
        retire(H1, 32'd0, 0, 0);
        chk("halt_set", {31'b0, HALT}, 32'd1);
        chk("halt_num", NUM_INST, 32'd6);
        retire(32'h00500093, 32'd77, 0, 0);
        chk("halt_ignore_num", NUM_INST, 32'd6);
        chk("halt_ignore_out", OUTPUT_PORT, 32'd0);
        idle(WD + 2);
        chk("halt_freezes_wdog", {31'b0, TIMEOUT}, 32'd0);

        // Intervening retire breaks the pair
        cycle(1, 0, 0, 0, 0, 0);
        retire(H0, 32'd12, 0, 0);
        retire(32'h00000013, 32'd0, 0, 0);
        retire(H1, 32'd0, 0, 0);
        chk("pair_broken", {31'b0, HALT}, 32'd0);

        // Idle cycles between the pair do not break it
        cycle(1, 0, 0, 0, 0, 0);
        retire(H0, 32'd12, 0, 0);
        idle(3);
        retire(H1, 32'd0, 0, 0);
        chk("pair_idle_gap", {31'b0, HALT}, 32'd1);

        // Watchdog expiry after exactly WD idle edges
        cycle(1, 0, 0, 0, 0, 0);
        idle(WD - 1);
        chk("wdog_before", {31'b0, TIMEOUT}, 32'd0);
        idle(1);
        chk("wdog_expire", {31'b0, TIMEOUT}, 32'd1);
        retire(32'h00700093, 32'd7, 0, 0);
        chk("timeout_no_block", NUM_INST, 32'd1);
        chk("timeout_sticky", {31'b0, TIMEOUT}, 32'd1);

        // Retire in the expiry cycle wins
        cycle(1, 0, 0, 0, 0, 0);
        idle(WD - 1);
        retire(32'h00700093, 32'd7, 0, 0);
        chk("wdog_retire_wins", {31'b0, TIMEOUT}, 32'd0);
        idle(WD - 1);
        chk("wdog_restart_before", {31'b0, TIMEOUT}, 32'd0);
        idle(1);
        chk("wdog_restart_expire", {31'b0, TIMEOUT}, 32'd1);

        // Saturation
        cycle(1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        force dut.num_inst_q = 32'hFFFFFFFE;
        #1;
        release dut.num_inst_q;
        m_cnt = 32'hFFFFFFFE;
        retire(32'h00100093, 32'd1, 0, 0);
        chk("sat_reach", NUM_INST, 32'hFFFFFFFF);
        retire(32'h00200093, 32'd2, 0, 0);
        chk("sat_hold", NUM_INST, 32'hFFFFFFFF);

        // Reset mid-run, with a retire in the same cycle
        cycle(1, 1, 32'h00300093, 32'd3, 0, 0);
        chk("rst_num", NUM_INST, 32'd0);
        chk("rst_out", OUTPUT_PORT, 32'd0);

        // Randomized traffic against the reference model
        last = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0 || (m_halt && $urandom_range(0, 19) == 0)) begin
                cycle(1, 0, 0, 0, 0, 0);
                last = 0;
            end else begin
                v = ($urandom_range(0, 9) < 6);
                inst = rand_inst(last);
                cycle(0, v, inst, $urandom, $urandom, 1'($urandom_range(0, 1)));
                if (v) last = inst;
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/riscv_retire_monitor.md
Name: riscv_retire_monitor

Overview:
- CPU-side producer of the retirement observation interface: NUM_INST, OUTPUT_PORT and HALT.
- Sits inside RISCV_TOP. It consumes one retire pulse per completed multicycle instruction and publishes the registered values that the external checker samples every posedge.
- Adds a sticky watchdog flag so a hung core is distinguishable from a slow one.

Parameters:
- HALT_INST0, 32'h00c00093, first word of the halt pair (addi x1,x0,12).
- HALT_INST1, 32'h00008067, second word of the halt pair (jalr x0,0(x1)).
- WDOG_CYCLES, 4096, idle cycles without a retire before TIMEOUT is set; 0 disables the watchdog.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous reset, active-high.
- RETIRE_VALID  in  1  one-cycle pulse: an instruction completed this cycle.
- RETIRE_INST  in  32  instruction word of the retiring instruction.
- RETIRE_WB_DATA  in  32  value written to the register file (RF_WD) by that instruction.
- RETIRE_MEM_ADDR  in  32  effective data-memory address (stores).
- RETIRE_BR_TAKEN  in  1  branch outcome (branches).
- NUM_INST  out  32  count of retired instructions.
- OUTPUT_PORT  out  32  observation value of the last retired instruction.
- HALT  out  1  sticky: halt pair has retired.
- TIMEOUT  out  1  sticky: watchdog expired.

Behaviour:
- Reset: NUM_INST=0, OUTPUT_PORT=0, HALT=0, TIMEOUT=0. prev_inst=0, prev_valid=0, idle counter=0. RST has priority over every other event, including mid-count.
- Accepted retire: RETIRE_VALID=1 && !HALT. Retires while HALT=1 are ignored entirely. TIMEOUT does not block retires.
- Latency: an accepted retire in cycle t updates the outputs at the edge closing cycle t, so they are visible in cycle t+1. Each retire is independent; back-to-back pulses are legal.
- NUM_INST: +1 per accepted retire. Saturates at 32'hFFFFFFFF and does not wrap.
- OUTPUT_PORT is selected by RETIRE_INST[6:0]:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD: RETIRE_WB_DATA.
  - STORE: RETIRE_MEM_ADDR.
  - BRANCH: {31'b0, RETIRE_BR_TAKEN}.
  - Any other opcode: OUTPUT_PORT holds its value, but NUM_INST still counts.
- Halt detection:
  - prev_inst and prev_valid are loaded on every accepted retire.
  - HALT is set on the edge where an accepted retire has RETIRE_INST==HALT_INST1 && prev_valid && prev_inst==HALT_INST0.
  - Both halt words are counted and update OUTPUT_PORT normally.
  - HALT_INST1 without an immediately preceding HALT_INST0 does not halt. Any intervening retired instruction breaks the pair; idle cycles between the two do not.
- Watchdog:
  - Idle counter width is $clog2(WDOG_CYCLES+1).
  - Cleared on any RETIRE_VALID. Frozen once HALT or TIMEOUT is set.
  - Otherwise +1 per cycle.
  - TIMEOUT is set on the edge where the counter reaches WDOG_CYCLES. A retire in that same cycle wins: counter clears and TIMEOUT is not set.
  - With WDOG_CYCLES=0, TIMEOUT stays 0.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - HALT word constants used as parameter defaults.
  - Already shared with the control unit.
- One sub-module: riscv_retire_wdog, containing the idle counter and TIMEOUT flag (inputs CLK, RST, RETIRE_VALID, HALT; param WDOG_CYCLES).
- Selection, counting and halt logic stay in the top module.

Test Plan:
- Reset, then retire addi (0x00500093, WB=5) -> next cycle NUM_INST=1, OUTPUT_PORT=5, HALT=0.
- sw (0x0020a023, MEM_ADDR=0x104) then beq (0x00208463, TAKEN=1), back-to-back -> OUTPUT_PORT=0x104 then 0x1, NUM_INST +2.
- Retire 0x00c00093, 0x00008067 -> HALT=1 after the second retire, counting both. A further retire -> NUM_INST and OUTPUT_PORT unchanged.
- Retire 0x00c00093, a nop, then 0x00008067 -> HALT stays 0.
- WDOG_CYCLES=8 with no retires -> TIMEOUT=1 exactly after 8 idle edges. Repeat with a retire in the 8th cycle -> TIMEOUT=0.
- Preload NUM_INST via 2^32-1 retires (force) plus one retire -> stays 0xFFFFFFFF. Assert RST mid-run -> all outputs 0 next edge.
